// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect selection and the IF/ID pipeline
// register, plus saturating stall and flush counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PC_WriteEnable,
    input  logic             IFID_WriteEnable,
    input  logic             StallFlush,
    input  logic [1:0]       ID_PCSrc,
    input  logic [31:0]      ID_BranchTarget,
    input  logic [31:0]      ID_JumpTarget,
    input  logic [31:0]      ID_RegTarget,
    input  logic [31:0]      IM_Instruction,
    output logic [31:0]      IM_Address,
    output logic [31:0]      PC,
    output logic [31:0]      IFID_Instruction,
    output logic [31:0]      IFID_PCPlus4,
    output logic             IFID_Valid,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign pc_plus4   = PC + 32'd4;
    assign IM_Address = PC;

    // A redirect request from decode only counts when decode holds a real instruction.
    assign redirect = IFID_Valid && (ID_PCSrc != 2'b00);

    always_comb begin
        target = pc_plus4;
        case (ID_PCSrc)
            2'b01:   target = word_align(ID_BranchTarget);
            2'b10:   target = word_align(ID_JumpTarget);
            2'b11:   target = word_align(ID_RegTarget);
            default: target = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            PC               <= RESET_PC;
            IFID_Instruction <= 32'h0000_0000;
            IFID_PCPlus4     <= 32'h0000_0000;
            IFID_Valid       <= 1'b0;
            StallCount       <= '0;
            FlushCount       <= '0;
        end else begin
            // A held PC leaves the redirecting instruction in decode to retry next cycle.
            if (PC_WriteEnable) begin
                PC <= redirect ? target : pc_plus4;
            end
            if (IFID_WriteEnable) begin
                if (redirect) begin
                    IFID_Instruction <= 32'h0000_0000;
                    IFID_PCPlus4     <= 32'h0000_0000;
                    IFID_Valid       <= 1'b0;
                end else begin
                    IFID_Instruction <= IM_Instruction;
                    IFID_PCPlus4     <= pc_plus4;
                    IFID_Valid       <= 1'b1;
                end
            end
            if (StallFlush) begin
                StallCount <= sat_inc(StallCount);
            end
            if (redirect && PC_WriteEnable && IFID_WriteEnable) begin
                FlushCount <= sat_inc(FlushCount);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk = 1'b0;
    logic             reset;
    logic             PC_WriteEnable, IFID_WriteEnable, StallFlush;
    logic [1:0]       ID_PCSrc;
    logic [31:0]      ID_BranchTarget, ID_JumpTarget, ID_RegTarget;
    logic [31:0]      IM_Instruction, IM_Address, PC;
    logic [31:0]      IFID_Instruction, IFID_PCPlus4;
    logic             IFID_Valid;
    logic [CNT_W-1:0] StallCount, FlushCount;

    logic [31:0] key = 32'h0;
    int vectors = 0;
    int miscompares = 0;

    // Instruction memory: each word is its own address, optionally scrambled by key.
    assign IM_Instruction = IM_Address ^ key;

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .PC_WriteEnable(PC_WriteEnable), .IFID_WriteEnable(IFID_WriteEnable),
        .StallFlush(StallFlush), .ID_PCSrc(ID_PCSrc),
        .ID_BranchTarget(ID_BranchTarget), .ID_JumpTarget(ID_JumpTarget),
        .ID_RegTarget(ID_RegTarget), .IM_Instruction(IM_Instruction),
        .IM_Address(IM_Address), .PC(PC),
        .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the architectural state.
    logic [31:0]      m_pc, m_ins, m_p4;
    logic             m_vld;
    logic [CNT_W-1:0] m_sc, m_fc;
    logic             model_ok = 1'b0;

    always @(posedge clk) begin : model
        logic        take;
        logic [31:0] dest;
        if (!reset) begin
            m_pc = 32'h0; m_ins = 32'h0; m_p4 = 32'h0; m_vld = 1'b0;
            m_sc = '0; m_fc = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            take = m_vld && (ID_PCSrc != 2'b00);
            dest = (ID_PCSrc == 2'b01) ? ID_BranchTarget :
                   (ID_PCSrc == 2'b10) ? ID_JumpTarget : ID_RegTarget;
            dest = dest & 32'hFFFF_FFFC;
            if (StallFlush && m_sc != CMAX) m_sc = m_sc + 1'b1;
            if (take && PC_WriteEnable && IFID_WriteEnable && m_fc != CMAX) m_fc = m_fc + 1'b1;
            if (IFID_WriteEnable) begin
                if (take) begin
                    m_ins = 32'h0; m_p4 = 32'h0; m_vld = 1'b0;
                end else begin
                    m_ins = m_pc ^ key; m_p4 = m_pc + 32'd4; m_vld = 1'b1;
                end
            end
            if (PC_WriteEnable) m_pc = take ? dest : m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("pc", PC, m_pc);
            chk("im_address", IM_Address, m_pc);
            chk("ifid_instr", IFID_Instruction, m_ins);
            chk("ifid_pcplus4", IFID_PCPlus4, m_p4);
            chk("ifid_valid", 32'(IFID_Valid), 32'(m_vld));
            chk("stall_count", 32'(StallCount), 32'(m_sc));
            chk("flush_count", 32'(FlushCount), 32'(m_fc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we_pc, input logic we_ifid, input logic sf,
                         input logic [1:0] src);
        PC_WriteEnable = we_pc; IFID_WriteEnable = we_ifid;
        StallFlush = sf; ID_PCSrc = src;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        ID_BranchTarget = 32'h0; ID_JumpTarget = 32'h0; ID_RegTarget = 32'h0;
        step(); step();
        chk("rst_pc", PC, 32'h0);
        chk("rst_valid", 32'(IFID_Valid), 32'h0);
        chk("rst_instr", IFID_Instruction, 32'h0);
        reset = 1'b1;
        #1;
        chk("first_im_address", IM_Address, 32'h0);

        // Sequential fetch from reset
        step();
        chk("seq1_pc", PC, 32'h4);
        chk("seq1_instr", IFID_Instruction, 32'h0);
        chk("seq1_p4", IFID_PCPlus4, 32'h4);
        chk("seq1_valid", 32'(IFID_Valid), 32'h1);
        step();
        chk("seq2_pc", PC, 32'h8);
        chk("seq2_instr", IFID_Instruction, 32'h4);
        step();
        chk("seq3_pc", PC, 32'hC);
        chk("seq3_instr", IFID_Instruction, 32'h8);
        chk("seq3_p4", IFID_PCPlus4, 32'hC);

        // Taken branch with a misaligned target
        ID_BranchTarget = 32'h0000_0103;
        drive(1'b1, 1'b1, 1'b0, 2'b01);
        step();
        chk("br_pc", PC, 32'h100);
        chk("br_bubble", 32'(IFID_Valid), 32'h0);
        chk("br_flushcnt", 32'(FlushCount), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        step();
        chk("br_after_pc", PC, 32'h104);
        chk("br_after_instr", IFID_Instruction, 32'h100);
        chk("br_after_valid", 32'(IFID_Valid), 32'h1);

        // Stall overrides a pending jump for two cycles
        ID_JumpTarget = 32'h0000_2000;
        drive(1'b0, 1'b0, 1'b1, 2'b10);
        step(); step();
        chk("stall_pc", PC, 32'h104);
        chk("stall_instr", IFID_Instruction, 32'h100);
        chk("stall_cnt", 32'(StallCount), 32'h2);
        chk("stall_flushcnt", 32'(FlushCount), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 2'b10);
        step();
        chk("jmp_pc", PC, 32'h2000);
        chk("jmp_valid", 32'(IFID_Valid), 32'h0);
        chk("jmp_flushcnt", 32'(FlushCount), 32'h2);

        // Jump-register ignored while decode holds a bubble
        ID_RegTarget = 32'h0000_5554;
        drive(1'b1, 1'b1, 1'b0, 2'b11);
        step();
        chk("jr_ign_pc", PC, 32'h2004);
        chk("jr_ign_flushcnt", 32'(FlushCount), 32'h2);

        // Wrap at the top of the address space
        ID_JumpTarget = 32'hFFFF_FFFF;
        drive(1'b1, 1'b1, 1'b0, 2'b10);
        step();
        chk("wrap_jmp_pc", PC, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        step();
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_p4", IFID_PCPlus4, 32'h0);
        chk("wrap_instr", IFID_Instruction, 32'hFFFF_FFFC);

        // Stall counter saturation, then reset in the middle of a stall and redirect
        drive(1'b1, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < (1 << CNT_W) + 5; i++) step();
        chk("sat_stallcnt", 32'(StallCount), 32'(CMAX));
        ID_BranchTarget = 32'h0000_0800;
        drive(1'b0, 1'b0, 1'b1, 2'b01);
        reset = 1'b0;
        step();
        chk("midrst_pc", PC, 32'h0);
        chk("midrst_instr", IFID_Instruction, 32'h0);
        chk("midrst_p4", IFID_PCPlus4, 32'h0);
        chk("midrst_valid", 32'(IFID_Valid), 32'h0);
        chk("midrst_stallcnt", 32'(StallCount), 32'h0);
        chk("midrst_flushcnt", 32'(FlushCount), 32'h0);
        reset = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset            = ($urandom_range(0, 99) != 0);
            PC_WriteEnable   = ($urandom_range(0, 3) != 0);
            IFID_WriteEnable = ($urandom_range(0, 3) != 0);
            StallFlush       = ($urandom_range(0, 2) == 0);
            ID_PCSrc         = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ID_BranchTarget  = $urandom;
            ID_JumpTarget    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                          : $urandom;
            ID_RegTarget     = $urandom;
            if ($urandom_range(0, 15) == 0) key = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
